// File: rtl/gate_scan_pkg.sv
// Shared types and defaults for the gate truth-table scanner.
// State encoding plus parameter defaults used by the top.
package gate_scan_pkg;

  localparam int N_INPUTS_DEF = 2;
  localparam int SETTLE_DEF   = 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } scan_state_t;

endpackage

// File: rtl/scan_settle_timer.sv
// Settle-time counter: held clear while load is high,
// expires on its last count so the FSM can move on.
module scan_settle_timer #(
  parameter int CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt;

  assign expired = !load && (cnt == W'(CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || load || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/gate_truth_table_scanner.sv
// Walks every input vector of an external gate, captures its
// truth table and flags a mismatch against a latched expectation.
module gate_truth_table_scanner
  import gate_scan_pkg::*;
#(
  parameter  int N_INPUTS      = N_INPUTS_DEF,
  parameter  int SETTLE_CYCLES = SETTLE_DEF,
  localparam int TW            = 2 ** N_INPUTS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TW-1:0]       expected,
  output logic [N_INPUTS-1:0] gate_in,
  input  logic                gate_o,
  output logic                busy,
  output logic                done,
  output logic [TW-1:0]       table_out,
  output logic                mismatch
);

  scan_state_t state_q, state_n;

  // One extra bit so the last-vector compare never wraps.
  logic [N_INPUTS:0] idx;
  logic [TW-1:0]     expected_q;
  logic [TW-1:0]     table_n;
  logic              last;
  logic              expired;

  assign gate_in = idx[N_INPUTS-1:0];
  assign last    = (idx == (N_INPUTS + 1)'(TW - 1));

  scan_settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (state_q != SETTLE),
    .expired (expired)
  );

  always_comb begin
    state_n = state_q;
    table_n = table_out;
    table_n[idx[N_INPUTS-1:0]] = gate_o;
    unique case (state_q)
      IDLE:    if (start) state_n = SETTLE;
      SETTLE:  if (expired) state_n = SAMPLE;
      SAMPLE:  state_n = last ? DONE : SETTLE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx        <= '0;
      expected_q <= '0;
      table_out  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mismatch   <= 1'b0;
    end else begin
      state_q <= state_n;
      done    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            idx        <= '0;
            table_out  <= '0;
            mismatch   <= 1'b0;
            expected_q <= expected;
            busy       <= 1'b1;
          end
        end
        SAMPLE: begin
          table_out <= table_n;
          // Compare the freshly completed table so mismatch lines up with done.
          if (last) begin
            done     <= 1'b1;
            mismatch <= (table_n != expected_q);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_table_scanner.sv
// Directed bench: two scanners (settle 1 and 3) each driving
// a mux-built AND gate; expectations are hand-computed.
module tb_gate_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_v = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] exp_v = 4'b0000;

  logic [1:0] gin1, gin2;
  logic       g1, g2;
  logic       busy1, busy2, done1, done2, mm1, mm2;
  logic [3:0] tab1, tab2;

  logic [1:0] o_gin;
  logic       o_busy, o_done, o_mm;
  logic [3:0] o_tab;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // AND built from a 2:1 mux
  assign g1 = gin1[1] ? gin1[0] : 1'b0;
  assign g2 = gin2[1] ? gin2[0] : 1'b0;

  gate_truth_table_scanner #(
    .N_INPUTS      (2),
    .SETTLE_CYCLES (1)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start_v & !sel),
    .expected  (exp_v),
    .gate_in   (gin1),
    .gate_o    (g1),
    .busy      (busy1),
    .done      (done1),
    .table_out (tab1),
    .mismatch  (mm1)
  );

  gate_truth_table_scanner #(
    .N_INPUTS      (2),
    .SETTLE_CYCLES (3)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .start     (start_v & sel),
    .expected  (exp_v),
    .gate_in   (gin2),
    .gate_o    (g2),
    .busy      (busy2),
    .done      (done2),
    .table_out (tab2),
    .mismatch  (mm2)
  );

  assign o_gin  = sel ? gin2  : gin1;
  assign o_busy = sel ? busy2 : busy1;
  assign o_done = sel ? done2 : done1;
  assign o_mm   = sel ? mm2   : mm1;
  assign o_tab  = sel ? tab2  : tab1;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: plain scan; mode 1: stray start pulses + expected toggling
  task automatic scan(input string tag, input logic s,
                      input logic [3:0] e, input logic [3:0] tab_w,
                      input logic mm_w, input int sc, input int mode);
    int dc;
    int vlen;
    vlen = sc + 1;
    dc = -1;
    sel = s;
    exp_v = e;
    start_v = 1'b1;
    step();
    start_v = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) check({tag, " busy1"}, int'(o_busy), 1);
      if ((c - 1) % vlen == 0 && c < 1 + 4 * vlen)
        check($sformatf("%s gin@%0d", tag, c), int'(o_gin), (c - 1) / vlen);
      if (o_done) begin
        dc = c;
        break;
      end
      if (mode == 1) begin
        if (c == 3) start_v = 1'b1;
        if (c == 4) start_v = 1'b0;
        if (c == 5) exp_v = ~e;
        if (c == 8) start_v = 1'b1;
      end
      step();
    end
    check({tag, " done_cyc"}, dc, 1 + 4 * vlen);
    check({tag, " table"}, int'(o_tab), int'(tab_w));
    check({tag, " mismatch"}, int'(o_mm), int'(mm_w));
    check({tag, " busy@done"}, int'(o_busy), 1);
    step();
    start_v = 1'b0;
    check({tag, " done_pulse"}, int'(o_done), 0);
    check({tag, " busy_end"}, int'(o_busy), 0);
    step();
    check({tag, " idle_busy"}, int'(o_busy), 0);
    check({tag, " hold_table"}, int'(o_tab), int'(tab_w));
    check({tag, " hold_mm"}, int'(o_mm), int'(mm_w));
  endtask

  initial begin
    int nd;
    int d1;
    int d2;

    step();
    step();
    check("rst busy", int'(busy1), 0);
    check("rst done", int'(done1), 0);
    check("rst gin", int'(gin1), 0);
    check("rst table", int'(tab1), 0);
    check("rst mm", int'(mm1), 0);
    check("rst gin2", int'(gin2), 0);
    rst = 1'b0;
    step();

    scan("and", 1'b0, 4'b1000, 4'b1000, 1'b0, 1, 0);
    scan("or", 1'b0, 4'b1110, 4'b1000, 1'b1, 1, 0);
    scan("sc3", 1'b1, 4'b1000, 4'b1000, 1'b0, 3, 0);
    scan("ign", 1'b0, 4'b1000, 4'b1000, 1'b0, 1, 1);

    // leave a mismatch set, then reset mid-scan
    scan("pre", 1'b0, 4'b0001, 4'b1000, 1'b1, 1, 0);
    sel = 1'b0;
    exp_v = 4'b1000;
    start_v = 1'b1;
    step();
    start_v = 1'b0;
    for (int c = 1; c < 4; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid busy", int'(busy1), 0);
    check("rst_mid gin", int'(gin1), 0);
    check("rst_mid table", int'(tab1), 0);
    check("rst_mid mm", int'(mm1), 0);
    nd = int'(done1);
    for (int c = 0; c < 15; c++) begin
      step();
      nd += int'(done1);
    end
    check("rst_mid no_done", nd, 0);

    // start held high: back-to-back scans
    sel = 1'b0;
    exp_v = 4'b1000;
    start_v = 1'b1;
    d1 = -1;
    d2 = -1;
    step();
    for (int c = 1; c <= 40; c++) begin
      if (done1) begin
        check($sformatf("held mm@%0d", c), int'(mm1), 0);
        check($sformatf("held tab@%0d", c), int'(tab1), 8);
        if (d1 < 0) d1 = c;
        else begin
          d2 = c;
          start_v = 1'b0;
          break;
        end
      end
      step();
    end
    check("held done1", d1, 9);
    check("held done2", d2, 19);
    for (int c = 0; c < 3; c++) step();
    check("held idle", int'(busy1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
